// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding modes, converter FSM states,
// single-precision field widths and the packed {sign, exp, mant} layout.
package fpu_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    // RISC-V static rounding-mode encodings
    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } fp_rm_e;

    // Converter FSM state encodings
    typedef enum logic [1:0] {
        FCVT_IDLE  = 2'd0,
        FCVT_NORM  = 2'd1,
        FCVT_ROUND = 2'd2,
        FCVT_RESP  = 2'd3
    } fcvt_state_e;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] mant;
    } sp_t;

endpackage

// File: rtl/fpu_fcvt_s_w_if.sv
// Issue-side and result-side handshake bundle for fpu_fcvt_s_w.
// FCVT_UNSIGNED_EN adds the signed0_unsigned1 operand qualifier.
//
// Handshake: a transfer happens on a rising clk edge where valid and
// ready are both high. A producer holds valid and its payload steady
// until that edge; ready may rise or fall regardless of valid.
interface fpu_fcvt_s_w_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rs1;
    logic [2:0]  rm;
`ifdef FCVT_UNSIGNED_EN
    logic        signed0_unsigned1;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [31:0] rd;
    logic        fflag_nx;

    // Issue logic / result consumer side
    modport master (
`ifdef FCVT_UNSIGNED_EN
        output signed0_unsigned1,
`endif
        output in_valid, rs1, rm, out_ready,
        input  in_ready, out_valid, rd, fflag_nx
    );

    // Converter side
    modport slave (
`ifdef FCVT_UNSIGNED_EN
        input  signed0_unsigned1,
`endif
        input  in_valid, rs1, rm, out_ready,
        output in_ready, out_valid, rd, fflag_nx
    );
endinterface

// File: rtl/fpu_lzc32.sv
// Combinational 32-bit leading-zero counter with an all-zero flag.
// count is don't-care (reads 0) when zero is high.
module fpu_lzc32 (
    input  logic [31:0] a,
    output logic [4:0]  count,
    output logic        zero
);

    // Highest set bit wins because later iterations overwrite earlier ones
    always_comb begin
        count = '0;
        for (int i = 0; i < 32; i++) begin
            if (a[i]) count = 5'(31 - i);
        end
        zero = ~|a;
    end

endmodule

// File: rtl/fpu_fcvt_s_w.sv
// fcvt.s.w / fcvt.s.wu: 32-bit integer to IEEE-754 single, four-state
// multi-cycle FSM (IDLE -> NORM -> ROUND -> RESP) with inexact flag.
// Optional macro FCVT_UNSIGNED_EN enables the unsigned (fcvt.s.wu) form.
module fpu_fcvt_s_w #(
    parameter int LZC_W = 5,
    parameter int BIAS  = fpu_pkg::BIAS
) (
    input  logic           clk,
    input  logic           rst,
    fpu_fcvt_s_w_if.slave  bus,
    output logic [1:0]     dbg_state
);
    import fpu_pkg::*;

    localparam logic [1:0] IDLE  = FCVT_IDLE;
    localparam logic [1:0] NORM  = FCVT_NORM;
    localparam logic [1:0] ROUND = FCVT_ROUND;
    localparam logic [1:0] RESP  = FCVT_RESP;

    logic [1:0]       state;
    logic [31:0]      op_q;
    logic [2:0]       rm_q;
    logic             sign_q;
    logic             zero_q;
    logic [LZC_W-1:0] lzc_q;
    logic [30:0]      shifted_q;   // normalised magnitude below the implicit one
    logic [31:0]      rd_q;
    logic             nx_q;

    // Signedness of the captured operand
    logic uns_c;
`ifdef FCVT_UNSIGNED_EN
    logic uns_q;
    assign uns_c = uns_q;
`else
    assign uns_c = 1'b0;
`endif

    // NORM stage: magnitude and leading-zero count
    logic             sign_c;
    logic [31:0]      mag_c;
    logic [LZC_W-1:0] lzc_c;
    logic             zero_c;

    assign sign_c = op_q[31] & ~uns_c;
    assign mag_c  = sign_c ? (~op_q + 32'd1) : op_q;

    fpu_lzc32 u_lzc (
        .a     (mag_c),
        .count (lzc_c),
        .zero  (zero_c)
    );

    // ROUND stage: exponent, round-up decision and packed result
    logic [MAN_W-1:0]       mant_c;
    logic                   guard_c;
    logic                   sticky_c;
    logic                   round_up_c;
    logic [EXP_W-1:0]       exp_c;
    logic [EXP_W+MAN_W-1:0] sum_c;
    sp_t                    res_c;
    logic                   nx_c;

    // Round to the target format; a mantissa carry ripples into exp
    always_comb begin
        mant_c   = shifted_q[30:8];
        guard_c  = shifted_q[7];
        sticky_c = |shifted_q[6:0];
        exp_c    = EXP_W'(BIAS + 31) - EXP_W'(lzc_q);
        case (rm_q)
            RM_RTZ:  round_up_c = 1'b0;
            RM_RDN:  round_up_c = sign_q & (guard_c | sticky_c);
            RM_RUP:  round_up_c = ~sign_q & (guard_c | sticky_c);
            RM_RMM:  round_up_c = guard_c;
            default: round_up_c = guard_c & (sticky_c | mant_c[0]);  // RNE and reserved
        endcase
        sum_c = {exp_c, mant_c} + (EXP_W+MAN_W)'(round_up_c);
        res_c = '0;
        nx_c  = 1'b0;
        if (!zero_q) begin
            res_c.sign = sign_q;
            res_c.exp  = sum_c[EXP_W+MAN_W-1:MAN_W];
            res_c.mant = sum_c[MAN_W-1:0];
            nx_c       = guard_c | sticky_c;
        end
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= '0;
            rm_q      <= '0;
            sign_q    <= 1'b0;
            zero_q    <= 1'b0;
            lzc_q     <= '0;
            shifted_q <= '0;
            rd_q      <= '0;
            nx_q      <= 1'b0;
`ifdef FCVT_UNSIGNED_EN
            uns_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_q  <= bus.rs1;
                        rm_q  <= bus.rm;
`ifdef FCVT_UNSIGNED_EN
                        uns_q <= bus.signed0_unsigned1;
`endif
                        state <= NORM;
                    end
                end
                NORM: begin
                    sign_q    <= sign_c;
                    zero_q    <= zero_c;
                    lzc_q     <= lzc_c;
                    shifted_q <= 31'(mag_c << lzc_c);
                    state     <= ROUND;
                end
                ROUND: begin
                    rd_q  <= res_c;
                    nx_q  <= nx_c;
                    state <= RESP;
                end
                default: begin
                    if (bus.out_ready) state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == RESP);
    assign bus.rd        = rd_q;
    assign bus.fflag_nx  = nx_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_fpu_fcvt_s_w.sv
// Directed bench for fpu_fcvt_s_w: reset state, conversions across
// rounding modes, zero, back-pressure and reset mid-operation.
module tb_fpu_fcvt_s_w;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    fpu_fcvt_s_w_if bus ();

    fpu_fcvt_s_w dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [32:0] exp_q[$];   // {nx, rd}

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one operand, wait for the result, check it and complete the handshake
    task automatic run_op(input string tag, input logic [31:0] a, input logic [2:0] m,
                          input logic u, input logic [31:0] e_rd, input logic e_nx);
        logic [32:0] e;
        int cycles;
        exp_q.push_back({e_nx, e_rd});
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.rs1      = a;
        bus.rm       = m;
`ifdef FCVT_UNSIGNED_EN
        bus.signed0_unsigned1 = u;
`else
        if (u) $display("note: unsigned operand requested without FCVT_UNSIGNED_EN");
`endif
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.rs1      = $urandom;
        bus.rm       = 3'($urandom_range(0, 7));
        cycles = 1;
        while (!bus.out_valid && cycles < 16) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check({tag, " latency"}, 32'(cycles), 32'd3);
        e = exp_q.pop_front();
        check({tag, " rd"}, bus.rd, e[31:0]);
        check({tag, " nx"}, 32'(bus.fflag_nx), 32'(e[32]));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, " back to idle"}, 32'(dbg_state), 32'd0);
    endtask

    initial begin
        int cycles;
        int seen;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.rs1       = '0;
        bus.rm        = '0;
        bus.out_ready = 1'b0;
`ifdef FCVT_UNSIGNED_EN
        bus.signed0_unsigned1 = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset state", 32'(dbg_state), 32'd0);
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset rd", bus.rd, 32'h0);
        check("reset nx", 32'(bus.fflag_nx), 32'd0);
        rst = 1'b0;

        run_op("one rne",       32'h0000_0001, 3'd0, 1'b0, 32'h3F80_0000, 1'b0);
        run_op("minus one",     32'hFFFF_FFFF, 3'd0, 1'b0, 32'hBF80_0000, 1'b0);
        run_op("max rne",       32'h7FFF_FFFF, 3'd0, 1'b0, 32'h4F00_0000, 1'b1);
        run_op("max rtz",       32'h7FFF_FFFF, 3'd1, 1'b0, 32'h4EFF_FFFF, 1'b1);
        run_op("min int",       32'h8000_0000, 3'd0, 1'b0, 32'hCF00_0000, 1'b0);
        run_op("tie rne",       32'h0100_0001, 3'd0, 1'b0, 32'h4B80_0000, 1'b1);
        run_op("tie rup",       32'h0100_0001, 3'd3, 1'b0, 32'h4B80_0001, 1'b1);
        run_op("tie rmm",       32'h0100_0001, 3'd4, 1'b0, 32'h4B80_0001, 1'b1);
        run_op("tie rsvd5",     32'h0100_0001, 3'd5, 1'b0, 32'h4B80_0000, 1'b1);
        run_op("odd tie rne",   32'h0100_0003, 3'd0, 1'b0, 32'h4B80_0002, 1'b1);
        run_op("pos rdn",       32'h0100_0003, 3'd2, 1'b0, 32'h4B80_0001, 1'b1);
        run_op("neg rdn",       32'h8000_0001, 3'd2, 1'b0, 32'hCF00_0000, 1'b1);
        run_op("neg rup",       32'h8000_0001, 3'd3, 1'b0, 32'hCEFF_FFFF, 1'b1);
        for (int m = 0; m < 5; m++) begin
            run_op($sformatf("zero rm%0d", m), 32'h0, 3'(m), 1'b0, 32'h0, 1'b0);
        end
`ifdef FCVT_UNSIGNED_EN
        run_op("unsigned max",  32'hFFFF_FFFF, 3'd0, 1'b1, 32'h4F80_0000, 1'b1);
        run_op("unsigned one",  32'h0000_0001, 3'd0, 1'b1, 32'h3F80_0000, 1'b0);
`endif

        // Back-pressure: result held while out_ready stays low
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.rs1      = 32'h7FFF_FFFF;
        bus.rm       = 3'd0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        cycles = 1;
        while (!bus.out_valid && cycles < 16) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("hold latency", 32'(cycles), 32'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.rs1      = 32'h0000_0001;
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            check($sformatf("hold in_ready %0d", i), 32'(bus.in_ready), 32'd0);
            check($sformatf("hold out_valid %0d", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("hold rd %0d", i), bus.rd, 32'h4F00_0000);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("hold release idle", 32'(dbg_state), 32'd0);
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        check("hold no second result", 32'(seen), 32'd0);

        // Reset while in NORM abandons the conversion
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.rs1      = 32'h0100_0001;
        bus.rm       = 3'd3;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("mid state norm", 32'(dbg_state), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid rst state", 32'(dbg_state), 32'd0);
        check("mid rst out_valid", 32'(bus.out_valid), 32'd0);
        check("mid rst rd", bus.rd, 32'h0);
        check("mid rst nx", 32'(bus.fflag_nx), 32'd0);
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        check("mid rst no result", 32'(seen), 32'd0);

        // Converter still works after the abandoned operation
        run_op("after rst", 32'h0000_0001, 3'd0, 1'b0, 32'h3F80_0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
